// File: rtl/prog_counter_if.sv
// Control and status bundle for prog_counter; the master drives controls, the slave returns count/status.
// Latency: none (wires only). Backpressure: none.
interface prog_counter_if #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);
    logic                  en;
    logic                  up;
    logic [1:0]            mode;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  running;
    logic                  dir;

    modport master (
        output en, up, mode, load, load_val, limit, prescale,
        input  count, tc, running, dir
    );

    modport slave (
        input  en, up, mode, load, load_val, limit, prescale,
        output count, tc, running, dir
    );
endinterface

// File: rtl/prog_counter.sv
// Programmable counter: prescaler, up/down, sync load, free/modulo/one-shot/ping-pong terminal behaviour.
// Latency: first tick prescale+1 enabled cycles after reset/load; tc registered with the post-terminal count. Backpressure: none, en=0 freezes state.
module prog_counter #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_counter_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_FREE     = 2'b00,
        MODE_MODULO   = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_PINGPONG = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0]      r_count;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_running;
    logic                  r_dir;
    logic                  r_tc;

    mode_e                 w_mode;
    logic [WIDTH-1:0]      w_inc;
    logic [WIDTH-1:0]      w_dec;
    logic                  w_at_limit;
    logic                  w_at_zero;
    logic                  w_active;
    logic                  w_tick;
    logic [WIDTH-1:0]      w_next_count;
    logic                  w_next_dir;
    logic                  w_next_running;
    logic                  w_hit;

    assign w_mode     = mode_e'(bus.mode);
    assign w_inc      = r_count + CNT_ONE;
    assign w_dec      = r_count - CNT_ONE;
    assign w_at_limit = (r_count >= bus.limit);
    assign w_at_zero  = (r_count == '0);
    assign w_active   = bus.en && r_running;
    assign w_tick     = w_active && (r_presc == bus.prescale);

    // Next count/dir/running if this edge turns out to be a tick; w_hit marks a terminal step.
    always_comb begin
        w_next_count   = r_count;
        w_next_dir     = r_dir;
        w_next_running = r_running;
        w_hit          = 1'b0;
        case (w_mode)
            MODE_FREE: begin
                if (bus.up) begin
                    w_next_count = w_inc;
                    w_hit        = (r_count == CNT_MAX);
                end else begin
                    w_next_count = w_dec;
                    w_hit        = w_at_zero;
                end
            end
            MODE_MODULO: begin
                if (bus.up) begin
                    if (w_at_limit) begin
                        w_next_count = '0;
                        w_hit        = 1'b1;
                    end else begin
                        w_next_count = w_inc;
                    end
                end else if (w_at_zero) begin
                    w_next_count = bus.limit;
                    w_hit        = 1'b1;
                end else begin
                    w_next_count = w_dec;
                end
            end
            MODE_ONESHOT: begin
                if ((bus.up && w_at_limit) || (!bus.up && w_at_zero)) begin
                    w_next_running = 1'b0;
                    w_hit          = 1'b1;
                end else begin
                    w_next_count = bus.up ? w_inc : w_dec;
                end
            end
            MODE_PINGPONG: begin
                // A zero limit pins the count at 0 while dir keeps bouncing.
                if (r_dir) begin
                    if (w_at_limit) begin
                        w_next_dir   = 1'b0;
                        w_next_count = w_at_zero ? '0 : w_dec;
                        w_hit        = 1'b1;
                    end else begin
                        w_next_count = w_inc;
                    end
                end else if (w_at_zero) begin
                    w_next_dir   = 1'b1;
                    w_next_count = (bus.limit == '0) ? '0 : CNT_ONE;
                    w_hit        = 1'b1;
                end else begin
                    w_next_count = w_dec;
                end
            end
            default: begin
                w_next_count = r_count;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_presc   <= '0;
            r_running <= 1'b1;
            r_dir     <= 1'b1;
            r_tc      <= 1'b0;
        end else if (bus.load) begin
            r_count   <= bus.load_val;
            r_presc   <= '0;
            r_running <= 1'b1;
            r_dir     <= bus.up;
            r_tc      <= 1'b0;
        end else if (w_tick) begin
            r_count   <= w_next_count;
            r_presc   <= '0;
            r_running <= w_next_running;
            r_dir     <= w_next_dir;
            r_tc      <= w_hit;
        end else begin
            // Prescaler phase is held across en gaps and while stopped.
            if (w_active) begin
                r_presc <= r_presc + PRESCALE_W'(1);
            end
            r_tc <= 1'b0;
        end
    end

    assign bus.count   = r_count;
    assign bus.tc      = r_tc;
    assign bus.running = r_running;
    assign bus.dir     = r_dir;
endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: behavioural model checked every cycle plus hand-computed literal points.
module tb_prog_counter;
    localparam int W  = 16;
    localparam int PW = 8;
    localparam int M  = 1 << W;

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    prog_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

    prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer arithmetic straight from the counting rules.
    int m_count, m_ph;
    bit m_tc, m_run, m_dir;

    function automatic void model_tick();
        int c   = m_count;
        int lim = int'(bus.limit);
        case (bus.mode)
            2'd0: begin
                m_count = bus.up ? (c + 1) % M : (c + M - 1) % M;
                m_tc    = bus.up ? (c == M - 1) : (c == 0);
            end
            2'd1: begin
                if (bus.up) begin
                    m_tc    = (c >= lim);
                    m_count = m_tc ? 0 : c + 1;
                end else begin
                    m_tc    = (c == 0);
                    m_count = m_tc ? lim : c - 1;
                end
            end
            2'd2: begin
                m_tc = bus.up ? (c >= lim) : (c == 0);
                if (m_tc) m_run = 1'b0;
                else      m_count = bus.up ? c + 1 : c - 1;
            end
            default: begin
                if (m_dir && c >= lim) begin
                    m_dir = 1'b0; m_tc = 1'b1; m_count = (c > 0) ? c - 1 : 0;
                end else if (!m_dir && c == 0) begin
                    m_dir = 1'b1; m_tc = 1'b1; m_count = (lim > 0) ? 1 : 0;
                end else begin
                    m_count = m_dir ? c + 1 : c - 1;
                end
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_ph = 0; m_run = 1'b1; m_dir = 1'b1; m_tc = 1'b0;
        end else if (bus.load) begin
            m_count = int'(bus.load_val); m_ph = 0; m_run = 1'b1; m_dir = bus.up; m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (bus.en && m_run) begin
                if (m_ph == int'(bus.prescale)) begin
                    m_ph = 0;
                    model_tick();
                end else begin
                    m_ph = (m_ph + 1) % (1 << PW);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_count",   32'(bus.count),   32'(m_count));
            chk("cmp_tc",      32'(bus.tc),      32'(m_tc));
            chk("cmp_running", 32'(bus.running), 32'(m_run));
            chk("cmp_dir",     32'(bus.dir),     32'(m_dir));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load     = 1'b0;
    endtask

    // Up to 8 ticks; cs holds expected counts first-to-last from the MSB end, ts the tc bits likewise.
    task automatic seq(input string nm, input int n, input logic [127:0] cs, input logic [7:0] ts);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_count%0d", nm, i), 32'(bus.count), 32'(cs[127 - 16*i -: 16]));
            chk($sformatf("%s_tc%0d", nm, i), 32'(bus.tc), 32'(ts[7 - i]));
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.mode     = 2'd0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.limit    = '0;
        bus.prescale = '0;
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        tick();
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_tc", 32'(bus.tc), 32'h0);
        chk("rst_running", 32'(bus.running), 32'h1);
        chk("rst_dir", 32'(bus.dir), 32'h1);
        rst_n  = 1'b1;
        bus.en = 1'b1;

        // FREE wrap up and down
        do_load(16'hFFFE);
        chk("free_load", 32'(bus.count), 32'hFFFE);
        seq("free_up", 3, {16'hFFFF, 16'h0000, 16'h0001, 80'h0}, 8'b0100_0000);
        chk("model_free", 32'(m_count), 32'h1);
        bus.up = 1'b0;
        do_load(16'h0001);
        seq("free_dn", 2, {16'h0000, 16'hFFFF, 96'h0}, 8'b0100_0000);

        // Prescaler phase preserved across an en gap
        bus.up = 1'b1;
        bus.prescale = 8'd2;
        do_load(16'h0000);
        seq("ps_a", 1, {16'h0000, 112'h0}, 8'h00);
        bus.en = 1'b0;
        seq("ps_gap", 5, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 48'h0}, 8'h00);
        bus.en = 1'b1;
        seq("ps_b", 5, {16'h0, 16'h1, 16'h1, 16'h1, 16'h2, 48'h0}, 8'h00);

        // MODULO up then down
        bus.prescale = 8'd0;
        bus.mode = 2'd1;
        bus.limit = 16'd4;
        do_load(16'h0000);
        seq("mod_up", 5, {16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 48'h0}, 8'b0000_1000);
        bus.up = 1'b0;
        do_load(16'h0001);
        seq("mod_dn", 3, {16'd0, 16'd4, 16'd3, 80'h0}, 8'b0100_0000);
        chk("model_mod", 32'(m_count), 32'd3);

        // MODULO limit 0: tc every tick; load beats a terminal tick
        bus.up = 1'b1;
        bus.limit = 16'd0;
        do_load(16'h0000);
        seq("mod0", 3, {16'd0, 16'd0, 16'd0, 80'h0}, 8'b1110_0000);
        do_load(16'h0002);
        chk("load_wins_count", 32'(bus.count), 32'd2);
        chk("load_wins_tc", 32'(bus.tc), 32'd0);

        // ONESHOT: single tc, stays stopped across a mode change, load restarts
        bus.mode = 2'd2;
        bus.limit = 16'd3;
        do_load(16'h0000);
        seq("os", 6, {16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3, 32'h0}, 8'b0001_0000);
        chk("os_running", 32'(bus.running), 32'd0);
        bus.mode = 2'd0;
        tick();
        chk("os_free_count", 32'(bus.count), 32'd3);
        chk("os_free_running", 32'(bus.running), 32'd0);
        bus.mode = 2'd2;
        do_load(16'h0000);
        chk("os_reload_running", 32'(bus.running), 32'd1);
        seq("os_resume", 1, {16'd1, 112'h0}, 8'h00);

        // PINGPONG limit 3 then limit 0
        bus.mode = 2'd3;
        do_load(16'h0000);
        seq("pp_a", 4, {16'd1, 16'd2, 16'd3, 16'd2, 64'h0}, 8'b0001_0000);
        chk("pp_dir_dn", 32'(bus.dir), 32'd0);
        seq("pp_b", 4, {16'd1, 16'd0, 16'd1, 16'd2, 64'h0}, 8'b0010_0000);
        chk("pp_dir_up", 32'(bus.dir), 32'd1);
        chk("model_pp", 32'(m_count), 32'd2);
        bus.limit = 16'd0;
        do_load(16'h0000);
        seq("pp0", 3, {16'd0, 16'd0, 16'd0, 80'h0}, 8'b1110_0000);
        chk("pp0_dir", 32'(bus.dir), 32'd0);

        // Async reset mid-count with prescaler mid-phase
        bus.mode = 2'd0;
        bus.prescale = 8'd3;
        do_load(16'h0000);
        for (int i = 0; i < 22; i++) tick();
        chk("ar_pre_count", 32'(bus.count), 32'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_tc", 32'(bus.tc), 32'd0);
        chk("ar_running", 32'(bus.running), 32'd1);
        chk("ar_dir", 32'(bus.dir), 32'd1);
        tick();
        rst_n = 1'b1;
        seq("ar_restart", 4, {16'd0, 16'd0, 16'd0, 16'd1, 64'h0}, 8'h00);

        tick();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised, programmable counter: the next-generation counting core for the TinyTapeout top level, replacing the fixed free-running 16-bit counter. Adds a clock prescaler, up/down direction, synchronous load, and four terminal behaviours (free-run, modulo, one-shot, ping-pong), with a registered terminal-count pulse. The top level drives `count[7:0]` onto `uo_out` and maps control inputs from `ui_in`/`uio_in`.

## Interface

Parameters:
- `WIDTH`, 16, counter width in bits (≥2)
- `PRESCALE_W`, 8, prescaler compare width in bits (≥1)

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `en` in 1: count enable; 0 freezes all state except `load` handling and clears `tc`
- `up` in 1: direction for modes 00–10 (1 = increment); sampled into `dir` on `load` for mode 11
- `mode` in 2: 00 FREE, 01 MODULO, 10 ONESHOT, 11 PINGPONG
- `load` in 1: synchronous load strobe, highest priority, acts regardless of `en`
- `load_val` in WIDTH: value loaded into `count`
- `limit` in WIDTH: terminal value for modes 01–11
- `prescale` in PRESCALE_W: tick every `prescale+1` enabled cycles
- `count` out WIDTH: current count (registered)
- `tc` out 1: terminal-count pulse, one cycle (registered)
- `running` out 1: 0 once ONESHOT has finished
- `dir` out 1: current direction (1 = up); meaningful in mode 11

## Operation

- Reset: `count`=0, prescaler=0, `running`=1, `dir`=1, `tc`=0.
- Priority per edge: reset > `load` > `en`=0 hold > tick > prescaler advance.
- `load`=1: `count`←`load_val`, prescaler←0, `running`←1, `dir`←`up`, `tc`←0.
- Prescaler: with `en`=1 and `running`=1, if prescaler==`prescale` then tick and prescaler←0, else prescaler+1. `prescale`=0 ⇒ tick every enabled cycle. Prescaler holds when `en`=0 or `running`=0.
- `tc` is 1 only in the cycle following a tick that hit a terminal condition; otherwise 0.
- FREE (00): count ±1 modulo 2^WIDTH. `tc` on wrap (up: max→0; down: 0→max). `limit` ignored.
- MODULO (01): up: `count`≥`limit` ⇒ `count`←0, `tc`; else +1. Down: `count`==0 ⇒ `count`←`limit`, `tc`; else −1.
- ONESHOT (10): up: `count`≥`limit` ⇒ hold, `running`←0, `tc`; else +1. Down: `count`==0 ⇒ hold, `running`←0, `tc`; else −1. Restart only via `load` or reset; `tc` pulses exactly once per run.
- PINGPONG (11): `dir`=1 and `count`≥`limit` ⇒ `dir`←0, `count`←`count`−1, `tc`. `dir`=0 and `count`==0 ⇒ `dir`←1, `count`←1, `tc`. Otherwise step per `dir`. `limit`=0 ⇒ `count` stays 0, `dir` toggles, `tc` on every tick. `limit`=1 ⇒ 0,1,0,1…
- All arithmetic is WIDTH-bit unsigned; comparisons unsigned.
- `mode`, `limit`, `up`, `prescale` changes take effect at the next tick; no implicit reset. Leaving ONESHOT with `running`=0 keeps the counter stopped until `load`.

## Timing

- Count latency: first tick `prescale+1` enabled cycles after reset release or `load`; `count` updates on that edge.
- `tc` is asserted coincident with the post-terminal `count` value, for exactly one cycle, and is never asserted on two consecutive cycles unless `prescale`=0 and every tick is terminal (e.g. MODULO with `limit`=0).
- `en` low forces `tc`=0 on the next edge; the prescaler phase is preserved across `en` gaps.
- Asynchronous reset mid-count clears all state immediately; the first tick comes `prescale+1` cycles after deassertion.
- `load` and a tick on the same edge: load wins, no `tc`.

## Test plan

- Reset/FREE: `prescale`=0, `up`=1, WIDTH=16, load 0xFFFE → count 0xFFFF, 0x0000 with `tc`=1 on the 0x0000 cycle only.
- Prescaler: `prescale`=2, FREE up from 0, `en` toggled low for 5 cycles after the 1st enabled cycle → count increments every 3 enabled cycles, phase preserved, `tc`=0 throughout.
- MODULO: `limit`=4, up from 0 → 0,1,2,3,4,0 with `tc` on 0; down loaded 1 → 1,0,4,3 with `tc` on 4.
- ONESHOT: `limit`=3, up from 0 → stops at 3, `running`=0, single `tc`; further cycles no change; `load` 0 → resumes.
- PINGPONG: `limit`=3, `up`=1, load 0 → 1,2,3,2,1,0,1 with `tc` on the 2-after-3 and the 1-after-0 cycles; `dir` flips accordingly; `limit`=0 → count stuck 0, `tc` every tick.
- Async reset mid-run (count 0x0005, prescaler mid-phase) → all outputs at reset values on the same cycle, restart correct after release.
